// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if
//   Bundles every signal between the gate-vector checker and its surroundings
//   except clock and reset.
//   master : the checker. It drives the stimulus and status and receives start
//            and the gate responses.
//   slave  : the environment. It drives start and the gate responses and
//            observes everything else.
//   Signals:
//     start                   sweep request
//     a_o, b_o                stimulus to the gate under test
//     dut_not/dut_and/dut_or  gate responses
//     busy, done, pass        sweep status
//     err_cnt                 saturating count of mismatching vectors
//     vec_idx                 current vector index
//     resp_valid, resp_data   per-vector response strobe for a logger
//     fail_valid/vec/resp     capture of the first mismatch
interface gate_vector_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a_o;
    logic             b_o;
    logic             dut_not;
    logic             dut_and;
    logic             dut_or;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       vec_idx;
    logic             resp_valid;
    logic [4:0]       resp_data;
    logic             fail_valid;
    logic [1:0]       fail_vec;
    logic [2:0]       fail_resp;

    modport master (
        input  start, dut_not, dut_and, dut_or,
        output a_o, b_o, busy, done, pass, err_cnt, vec_idx,
               resp_valid, resp_data, fail_valid, fail_vec, fail_resp
    );

    modport slave (
        output start, dut_not, dut_and, dut_or,
        input  a_o, b_o, busy, done, pass, err_cnt, vec_idx,
               resp_valid, resp_data, fail_valid, fail_vec, fail_resp
    );
endinterface

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Sweeps the four 2-input vectors (00, 01, 10, 11) into a NOT/AND/OR gate
//   block. For each vector it waits SETTLE_CYCLES, then samples the responses
//   against the truth table. It counts mismatching vectors (saturating),
//   captures the first failure and reports pass/fail when the sweep is done.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    gate_vector_checker_if.master (stimulus, responses, status)
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gate_vector_checker_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int             SCW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SCW-1:0]   r_cnt;
    logic [1:0]       r_vec;
    logic [CNT_W-1:0] r_err;
    logic             r_pass;
    logic             r_resp_valid;
    logic [4:0]       r_resp_data;
    logic             r_fail_valid;
    logic [1:0]       r_fail_vec;
    logic [2:0]       r_fail_resp;

    logic [2:0]       w_exp;
    logic [2:0]       w_resp;
    logic             w_mis;
    logic [CNT_W-1:0] w_err_nxt;
    logic             w_last_vec;

    // The stimulus is the vector index itself, so a_o/b_o can never disagree
    // with vec_idx.
    assign w_exp      = {~r_vec[1], r_vec[1] & r_vec[0], r_vec[1] | r_vec[0]};
    assign w_resp     = {bus.dut_not, bus.dut_and, bus.dut_or};
    assign w_mis      = (w_exp != w_resp);
    assign w_err_nxt  = (w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;
    assign w_last_vec = (r_vec == 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic. start is ignored while a sweep is in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_SETTLE;
            S_SETTLE:       if (r_cnt == SC_LAST) w_state_nxt = S_SAMPLE;
            S_SAMPLE:       w_state_nxt = w_last_vec ? S_DONE : S_SETTLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vector index, settle counter, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_vec        <= 2'd0;
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 5'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 2'd0;
            r_fail_resp  <= 3'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_cnt        <= '0;
                        r_vec        <= 2'd0;
                        r_err        <= '0;
                        r_pass       <= 1'b0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= 2'd0;
                        r_fail_resp  <= 3'd0;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + 1'b1;
                S_SAMPLE: begin
                    r_err        <= w_err_nxt;
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= {r_vec, w_resp};
                    // Only the first mismatch of a sweep is captured.
                    if (w_mis && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_vec   <= r_vec;
                        r_fail_resp  <= w_resp;
                    end
                    if (w_last_vec) begin
                        // Uses the post-update count so vector 3 is included.
                        r_pass <= (w_err_nxt == '0);
                    end else begin
                        r_vec <= r_vec + 2'd1;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a_o        = r_vec[1];
    assign bus.b_o        = r_vec[0];
    assign bus.vec_idx    = r_vec;
    assign bus.busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = r_pass;
    assign bus.err_cnt    = r_err;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;
    assign bus.fail_resp  = r_fail_resp;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
//   Drives two checkers from a common start and reset.
//   - The first checker (CNT_W=8) watches a gate model whose responses are the
//     ideal truth table XORed with a per-vector fault mask.
//   - The second checker (CNT_W=2) watches a gate whose outputs are all
//     inverted, so its error count has to saturate.
//   Expected values come from the truth table and the mask, using plain
//   arithmetic.
module tb_gate_vector_checker;
    localparam int SC = 2;
    localparam int P  = SC + 1;   // edges per vector
    localparam int NE = 4 * P;    // edges from start to done

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0][2:0] mask = '0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gate_vector_checker_if #(.CNT_W(8)) bus ();
    gate_vector_checker_if #(.CNT_W(2)) bus2 ();

    gate_vector_checker #(.SETTLE_CYCLES(SC), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    gate_vector_checker #(.SETTLE_CYCLES(SC), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    // Truth table for vector v = {a,b}: {not a, a and b, a or b}
    function automatic logic [2:0] ideal(input int v);
        int a, b;
        a = v / 2;
        b = v % 2;
        return {1'(1 - a), 1'(a * b), (a + b) > 0};
    endfunction

    assign bus.start  = start;
    assign bus2.start = start;
    assign {bus.dut_not, bus.dut_and, bus.dut_or} =
        ideal(int'({bus.a_o, bus.b_o})) ^ mask[{bus.a_o, bus.b_o}];
    assign {bus2.dut_not, bus2.dut_and, bus2.dut_or} =
        ideal(int'({bus2.a_o, bus2.b_o})) ^ 3'b111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dut"}, 32'({bus.a_o, bus.b_o, bus.busy, bus.done, bus.pass, bus.err_cnt,
                                bus.vec_idx, bus.resp_valid, bus.resp_data, bus.fail_valid,
                                bus.fail_vec, bus.fail_resp}), 32'd0);
        chk({tag, "_dut2"}, 32'({bus2.a_o, bus2.b_o, bus2.busy, bus2.done, bus2.pass, bus2.err_cnt,
                                 bus2.vec_idx, bus2.resp_valid, bus2.resp_data, bus2.fail_valid,
                                 bus2.fail_vec, bus2.fail_resp}), 32'd0);
    endtask

    // One full sweep with fault mask m. start is re-pulsed before edge ign_k
    // (0 = never) and must be ignored.
    task automatic sweep(input string name, input logic [3:0][2:0] m, input int ign_k);
        int errs, fv, e2, v;
        logic [2:0] fr;
        mask = m;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        chk({name, "_startclr"},
            32'({bus.busy, bus.done, bus.pass, bus.fail_valid, bus.vec_idx, bus.err_cnt}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}));
        for (int k = 1; k <= NE; k++) begin
            @(negedge clk); start = (k == ign_k);
            @(posedge clk); #1;
            v = (k < NE) ? k / P : 3;
            chk($sformatf("%s_cyc%0d", name, k),
                32'({bus.busy, bus.done, bus.vec_idx, bus.a_o, bus.b_o, bus.resp_valid}),
                32'({k < NE, k == NE, 2'(v), 1'(v / 2), 1'(v % 2), (k % P) == 0}));
            if ((k % P) == 0)
                chk($sformatf("%s_resp%0d", name, k / P - 1), 32'(bus.resp_data),
                    32'({2'(k / P - 1), ideal(k / P - 1) ^ m[k / P - 1]}));
        end
        @(negedge clk); start = 1'b0;
        errs = 0;
        fv   = -1;
        for (int i = 0; i < 4; i++)
            if (m[i] != 3'd0) begin
                errs++;
                if (fv < 0) fv = i;
            end
        fr = (fv < 0) ? 3'd0 : ideal(fv) ^ m[fv];
        chk({name, "_errcnt"}, 32'(bus.err_cnt), 32'((errs > 255) ? 255 : errs));
        chk({name, "_pass"}, 32'(bus.pass), 32'(errs == 0));
        chk({name, "_fail"}, 32'({bus.fail_valid, bus.fail_vec, bus.fail_resp}),
            32'({errs > 0, 2'((fv < 0) ? 0 : fv), fr}));
        // All four vectors mismatch on the inverted gate; 2-bit count saturates.
        e2 = 4;
        if (e2 > 3) e2 = 3;
        chk({name, "_sat2"},
            32'({bus2.done, bus2.pass, bus2.err_cnt, bus2.fail_valid, bus2.fail_vec, bus2.fail_resp}),
            32'({1'b1, 1'b0, 2'(e2), 1'b1, 2'd0, ideal(0) ^ 3'b111}));
    endtask

    initial begin
        logic [3:0][2:0] rm;
        #12;
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_nostart", 32'({bus.busy, bus.done}), 32'd0);

        sweep("ideal", '0, 0);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        chk("done_hold", 32'({bus.done, bus.busy, bus.vec_idx, bus.resp_valid, bus.pass, bus.err_cnt}),
            32'({1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 8'd0}));

        rm = '0; rm[3] = 3'b010;          // AND stuck at 0: only 11 is affected
        sweep("and_sa0", rm, 0);
        rm = {4{3'b001}};                 // OR inverted on every vector
        sweep("or_inv", rm, 0);
        sweep("ign_start", '0, 4);        // re-start during SETTLE of vector 1
        sweep("restart", '0, 0);          // start from DONE clears on that edge

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++)
                rm[j] = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            sweep($sformatf("rand%0d", i), rm, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, NE)) : 0);
        end

        // Asynchronous reset in the middle of vector 2 settle
        mask = 12'hfff;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (2 * P + 1) @(posedge clk);
        #1;
        chk("pre_reset", 32'({bus.busy, bus.vec_idx}), 32'({1'b1, 2'd2}));
        #2; rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk); rst_n = 1'b1;
        sweep("post_rst", '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Hardware-side counterpart of the gate truth-table stimulus flow. It drives the 2-input vector sweep (a,b = 00, 01, 10, 11) into a gate DUT, then waits a programmable settle time.
- It samples the DUT's out_not/out_and/out_or responses and checks them against the expected truth table. It counts mismatches, captures the first failure and reports pass/fail.
- It sits beside the gate block in self-checking bring-up and regression builds. Its per-vector response strobe feeds a logger.

Parameters:
- SETTLE_CYCLES, 2, cycles held in SETTLE per vector before sampling; legal range >= 1.
- CNT_W, 8, width of the error counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- a_o  out  1  stimulus a to DUT.
- b_o  out  1  stimulus b to DUT.
- dut_not  in  1  DUT response; expected ~a.
- dut_and  in  1  DUT response; expected a&b.
- dut_or  in  1  DUT response; expected a|b.
- busy  out  1  high in SETTLE/SAMPLE.
- done  out  1  high in DONE (level).
- pass  out  1  valid when done; 1 iff err_cnt==0.
- err_cnt  out  CNT_W  mismatching vectors this sweep, saturating.
- vec_idx  out  2  current vector index; a_o=vec_idx[1], b_o=vec_idx[0].
- resp_valid  out  1  one-cycle pulse per sampled vector.
- resp_data  out  5  {a,b,dut_not,dut_and,dut_or} at sample; valid with resp_valid.
- fail_valid  out  1  a mismatch has been captured this sweep.
- fail_vec  out  2  index of the first mismatching vector.
- fail_resp  out  3  {dut_not,dut_and,dut_or} of the first mismatch.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs are 0, including a_o, b_o, vec_idx, err_cnt, fail_*, resp_*, busy, done and pass.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - vec_idx<=0, a_o/b_o<=0/0.
  - err_cnt, fail_valid, fail_vec, fail_resp, pass and done are cleared.
  - Settle counter <=0; state moves to SETTLE.
- SETTLE: the counter increments each cycle. When counter==SETTLE_CYCLES-1, the state moves to SAMPLE on the next edge. Stimulus is held constant.
- SAMPLE (one cycle); at the edge leaving SAMPLE:
  - Compute expected {~a,a&b,a|b} from a_o/b_o and compare with {dut_not,dut_and,dut_or}. Any bit different counts as one mismatch for that vector.
  - On mismatch, err_cnt increments, saturating at all-ones. If fail_valid==0, fail_vec<=vec_idx, fail_resp<=response and fail_valid<=1. Later mismatches do not overwrite the capture.
  - resp_valid<=1 for exactly the following cycle, and resp_data is registered.
  - If vec_idx==3: state->DONE, done<=1, pass<=(final err_cnt==0), including this vector's result. a_o/b_o hold the last vector.
  - Else: vec_idx++, a_o/b_o<=new vector, settle counter<=0, state->SETTLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 4*(SETTLE_CYCLES+1) edges after the start edge, i.e. 12 with defaults.
  - busy=1 from the edge after start until done rises.
- start while busy is ignored, with no restart or state change.
- DONE holds all results indefinitely until start or reset. start in DONE begins a fresh sweep with results cleared on the same edge.
- Reset mid-sweep aborts immediately to IDLE with all outputs 0. No partial results are retained.
- DUT inputs are treated as synchronous to clk; no synchronizers are required.

Test Plan:
- Ideal DUT model (not=~a, and=a&b, or=a|b), defaults, 1-cycle start pulse -> a_o/b_o step 00,01,10,11 every 3 cycles; 4 resp_valid pulses; done=1 exactly 12 edges after start; pass=1, err_cnt=0, fail_valid=0.
- DUT with dut_and stuck at 0 -> err_cnt=1, fail_vec=3, fail_resp=3'b001, pass=0.
- DUT with dut_or inverted -> err_cnt=4, fail_vec=0, fail_resp=3'b101; capture unchanged by later mismatches.
- CNT_W=2 with all three outputs inverted -> err_cnt saturates at 3 (not wrapping to 0); pass=0; fail_vec=0, fail_resp=3'b011.
- start pulsed again during SETTLE of vector 1 -> ignored; sweep completes at cycle 12 unchanged. Then start in DONE -> done, err_cnt and fail_valid clear on that edge, and a second sweep completes 12 edges later.
- rst_n asserted asynchronously mid-SETTLE of vector 2 (between edges) -> all outputs 0 immediately. After release with start, the full sweep restarts at vector 0 with the expected results.
